fetch_bus_if: RTL and testbench

- Instruction-fetch bus master directly upstream of the IF pipeline register.
- Takes the word fetch address (the current IF PC) and runs a request/grant/address-strobe/ready transaction on the shared bus.
- Drives the fetched instruction word and a busy flag. The pipeline controller turns busy into the IF-stage stall.

---
 rtl/fetch_bus_if.sv | 179 +++++++++++++++++
 tb/tb_fetch_bus_if.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bus_if.sv
// Instruction-fetch bus master: one req/grant/strobe/ready read per fetch, feeding the IF stage.
// Build option: define FETCH_TIMEOUT_EN to abort a fetch stuck in REQ/ACCESS for TIMEOUT cycles.

`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0013
`endif

module fetch_bus_if #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] insn,
    output logic              busy,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as,
    output logic              bus_rw,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy,
    output logic              bus_err
);

    localparam logic [DATA_W-1:0] NopWord = DATA_W'(`ISA_NOP);

    typedef enum logic [1:0] {StIdle, StReq, StAccess, StHold} state_e;

    state_e              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_as_q, bus_as_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   insn_q, insn_d;
    logic                drop_q, drop_d;
    logic                bus_err_q, bus_err_d;
    logic                timeout_hit;
    logic                in_xfer;

    assign in_xfer = (state_q == StReq) || (state_q == StAccess);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Held at zero outside REQ/ACCESS, so it starts from zero on every REQ entry.
    always_comb begin
        cnt_d = '0;
        if (in_xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = in_xfer && (cnt_q == CntW'(TIMEOUT - 1));
`else
    // No counter in this build; the abort path can never fire.
    assign timeout_hit = (TIMEOUT == 0) & 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_as_d   = 1'b0;
        bus_addr_d = bus_addr_q;
        insn_d     = insn_q;
        drop_d     = drop_q;
        bus_err_d  = 1'b0;
        busy       = 1'b0;
        insn       = insn_q;

        unique case (state_q)
            StIdle: begin
                // The abort pulse cycle reports the NOP as a finished fetch.
                if (fetch_en && !flush && !bus_err_q) begin
                    busy       = 1'b1;
                    bus_req_d  = 1'b1;
                    bus_addr_d = fetch_addr;
                    state_d    = StReq;
                end
            end

            StReq: begin
                busy = 1'b1;
                if (flush) begin
                    bus_req_d = 1'b0;
                    state_d   = StIdle;
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    insn_d    = NopWord;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else if (bus_grant) begin
                    bus_as_d = 1'b1;
                    state_d  = StAccess;
                end
            end

            StAccess: begin
                if (bus_rdy) begin
                    bus_req_d = 1'b0;
                    if (drop_q || flush) begin
                        // Strobed read had to complete on the bus; its data is discarded.
                        insn    = NopWord;
                        insn_d  = NopWord;
                        drop_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        insn    = bus_rd_data;
                        insn_d  = bus_rd_data;
                        state_d = stall ? StHold : StIdle;
                    end
                end else if (timeout_hit) begin
                    busy      = 1'b1;
                    bus_req_d = 1'b0;
                    insn_d    = NopWord;
                    drop_d    = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    busy = 1'b1;
                    if (flush) begin
                        drop_d = 1'b1;
                    end
                end
            end

            StHold: begin
                if (!stall || flush) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bus_req_q  <= 1'b0;
            bus_as_q   <= 1'b0;
            bus_addr_q <= '0;
            insn_q     <= NopWord;
            drop_q     <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_as_q   <= bus_as_d;
            bus_addr_q <= bus_addr_d;
            insn_q     <= insn_d;
            drop_q     <= drop_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_req  = bus_req_q;
    assign bus_as   = bus_as_q;
    assign bus_addr = bus_addr_q;
    assign bus_rw   = 1'b1;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_fetch_bus_if.sv
// Directed bench for fetch_bus_if: normal fetch, stall/HOLD, flushes, back-to-back, reset, timeout.
`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0013
`endif

module tb_fetch_bus_if;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] NOP = `ISA_NOP;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] insn;
    logic              busy;
    logic              bus_req;
    logic              bus_grant;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy;
    logic              bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_bus_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .stall      (stall),
        .flush      (flush),
        .insn       (insn),
        .busy       (busy),
        .bus_req    (bus_req),
        .bus_grant  (bus_grant),
        .bus_addr   (bus_addr),
        .bus_as     (bus_as),
        .bus_rw     (bus_rw),
        .bus_rd_data(bus_rd_data),
        .bus_rdy    (bus_rdy),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
        bus_grant = 1'b0; bus_rd_data = '0; bus_rdy = 1'b0;
        step(); step();
        settle();
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_as", 32'(bus_as), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_insn", insn, NOP);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rw_const", 32'(bus_rw), 32'd1);

        // Normal fetch: grant on 2nd REQ cycle, rdy two cycles after the strobe.
        step(); reset = 1'b0; fetch_en = 1'b1; fetch_addr = 30'h10; settle();
        chk("t1_idle_busy", 32'(busy), 32'd1);
        step(); fetch_en = 1'b0; fetch_addr = 30'h55; settle();
        chk("t1_req", 32'(bus_req), 32'd1);
        chk("t1_req_addr", 32'(bus_addr), 32'h10);
        chk("t1_req_as", 32'(bus_as), 32'd0);
        chk("t1_req_busy", 32'(busy), 32'd1);
        step(); bus_grant = 1'b1; settle();
        chk("t1_req2_as", 32'(bus_as), 32'd0);
        chk("t1_req2_busy", 32'(busy), 32'd1);
        step(); bus_grant = 1'b0; settle();
        chk("t1_as", 32'(bus_as), 32'd1);
        chk("t1_as_addr", 32'(bus_addr), 32'h10);
        chk("t1_as_busy", 32'(busy), 32'd1);
        step(); settle();
        chk("t1_as_single", 32'(bus_as), 32'd0);
        chk("t1_wait_busy", 32'(busy), 32'd1);
        step(); bus_rdy = 1'b1; bus_rd_data = 32'h1234_5678; settle();
        chk("t1_rdy_insn", insn, 32'h1234_5678);
        chk("t1_rdy_busy", 32'(busy), 32'd0);
        step(); bus_rdy = 1'b0; bus_rd_data = '0; settle();
        chk("t1_after_req", 32'(bus_req), 32'd0);
        chk("t1_after_insn", insn, 32'h1234_5678);
        chk("t1_after_busy", 32'(busy), 32'd0);

        // Stall during rdy and three cycles after: HOLD keeps the word.
        fetch_en = 1'b1; fetch_addr = 30'h20;
        step(); fetch_en = 1'b0; bus_grant = 1'b1; settle();
        chk("t2_addr", 32'(bus_addr), 32'h20);
        step(); bus_grant = 1'b0; stall = 1'b1; bus_rdy = 1'b1; bus_rd_data = 32'hCAFE_F00D;
        settle();
        chk("t2_rdy_insn", insn, 32'hCAFE_F00D);
        chk("t2_rdy_busy", 32'(busy), 32'd0);
        step(); bus_rdy = 1'b0; bus_rd_data = '0; fetch_en = 1'b1; fetch_addr = 30'h30;
        settle();
        chk("t2_hold1_insn", insn, 32'hCAFE_F00D);
        chk("t2_hold1_busy", 32'(busy), 32'd0);
        chk("t2_hold1_req", 32'(bus_req), 32'd0);
        step(); settle();
        chk("t2_hold2_insn", insn, 32'hCAFE_F00D);
        step(); settle();
        chk("t2_hold3_req", 32'(bus_req), 32'd0);
        chk("t2_hold3_busy", 32'(busy), 32'd0);
        step(); stall = 1'b0; settle();
        chk("t2_hold4_req", 32'(bus_req), 32'd0);
        chk("t2_hold4_insn", insn, 32'hCAFE_F00D);
        step(); settle();
        chk("t2_idle_busy", 32'(busy), 32'd1);
        chk("t2_idle_req", 32'(bus_req), 32'd0);
        step(); settle();
        chk("t2_next_req", 32'(bus_req), 32'd1);
        chk("t2_next_addr", 32'(bus_addr), 32'h30);

        // Flush in REQ before grant.
        flush = 1'b1; fetch_en = 1'b0;
        step(); flush = 1'b0; bus_grant = 1'b1; settle();
        chk("t3_req_drop", 32'(bus_req), 32'd0);
        chk("t3_no_as", 32'(bus_as), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        step(); bus_grant = 1'b0; settle();
        chk("t3_idle_as", 32'(bus_as), 32'd0);
        chk("t3_idle_req", 32'(bus_req), 32'd0);

        // Flush one cycle after the strobe; rdy two cycles later is discarded.
        fetch_en = 1'b1; fetch_addr = 30'h40;
        step(); fetch_en = 1'b0; bus_grant = 1'b1; settle();
        step(); bus_grant = 1'b0; settle();
        chk("t4_as", 32'(bus_as), 32'd1);
        step(); flush = 1'b1; settle();
        chk("t4_flush_busy", 32'(busy), 32'd1);
        step(); flush = 1'b0; settle();
        chk("t4_drop_busy", 32'(busy), 32'd1);
        step(); bus_rdy = 1'b1; bus_rd_data = 32'hDEAD_BEEF; settle();
        chk("t4_rdy_busy", 32'(busy), 32'd0);
        chk("t4_rdy_hidden", 32'(insn == 32'hDEAD_BEEF), 32'd0);
        step(); bus_rdy = 1'b0; bus_rd_data = '0; settle();
        chk("t4_insn_nop", insn, NOP);
        chk("t4_req", 32'(bus_req), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Flush together with rdy, then back-to-back fetches with fetch_en held.
        fetch_en = 1'b1; fetch_addr = 30'h50;
        step(); fetch_en = 1'b0; bus_grant = 1'b1; settle();
        step(); bus_grant = 1'b0; flush = 1'b1; bus_rdy = 1'b1; bus_rd_data = 32'h1111_1111;
        settle();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_hidden", 32'(insn == 32'h1111_1111), 32'd0);
        step(); flush = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0; fetch_en = 1'b1;
        fetch_addr = 30'h60; settle();
        chk("t5_insn_nop", insn, NOP);
        step(); bus_grant = 1'b1; settle();
        step(); bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h0BAD_C0DE;
        fetch_addr = 30'h64; settle();
        chk("t6_rdy_insn", insn, 32'h0BAD_C0DE);
        chk("t6_rdy_busy", 32'(busy), 32'd0);
        step(); bus_rdy = 1'b0; bus_rd_data = '0; settle();
        chk("t6_gap_req", 32'(bus_req), 32'd0);
        chk("t6_gap_busy", 32'(busy), 32'd1);
        step(); fetch_en = 1'b0; bus_grant = 1'b1; settle();
        chk("t6_req2", 32'(bus_req), 32'd1);
        chk("t6_req2_addr", 32'(bus_addr), 32'h64);

        // Reset while in ACCESS; late rdy must not be captured.
        step(); bus_grant = 1'b0; settle();
        chk("t7_as", 32'(bus_as), 32'd1);
        step(); reset = 1'b1; settle();
        step(); bus_rdy = 1'b1; bus_rd_data = 32'h7777_7777; settle();
        chk("t7_rst_req", 32'(bus_req), 32'd0);
        chk("t7_rst_as", 32'(bus_as), 32'd0);
        chk("t7_rst_addr", 32'(bus_addr), 32'd0);
        chk("t7_rst_insn", insn, NOP);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        step(); reset = 1'b0; settle();
        chk("t7_late_insn", insn, NOP);
        chk("t7_late_busy", 32'(busy), 32'd0);
        step(); bus_rdy = 1'b0; bus_rd_data = '0; settle();
        chk("t7_late_req", 32'(bus_req), 32'd0);
        chk("t7_late_insn2", insn, NOP);

        // Granted fetch with no rdy (cycle 0 = first REQ cycle).
        fetch_en = 1'b1; fetch_addr = 30'h70;
        step(); fetch_en = 1'b0; bus_grant = 1'b1; settle();
        step(); bus_grant = 1'b0; settle();
        for (int n = 2; n <= 7; n++) begin
            step(); settle();
        end
        chk("t8_c7_busy", 32'(busy), 32'd1);
        chk("t8_c7_err", 32'(bus_err), 32'd0);
        step(); settle();
`ifdef FETCH_TIMEOUT_EN
        chk("t8_err_pulse", 32'(bus_err), 32'd1);
        chk("t8_err_insn", insn, NOP);
        chk("t8_err_busy", 32'(busy), 32'd0);
        chk("t8_err_req", 32'(bus_req), 32'd0);
        step(); settle();
        chk("t8_err_end", 32'(bus_err), 32'd0);
`else
        chk("t8_wait_err", 32'(bus_err), 32'd0);
        chk("t8_wait_busy", 32'(busy), 32'd1);
        chk("t8_wait_req", 32'(bus_req), 32'd1);
        step(); bus_rdy = 1'b1; bus_rd_data = 32'h2222_2222; settle();
        chk("t8_late_insn", insn, 32'h2222_2222);
        chk("t8_late_busy", 32'(busy), 32'd0);
        step(); bus_rdy = 1'b0; settle();
        chk("t8_done_req", 32'(bus_req), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
